// File: rtl/sync_sp_ram_arb2.sv
// Two-port round-robin front end for a single 64-bit byte-enabled synchronous RAM,
// with optional post-reset zero fill and fixed-latency per-port responses.
module sync_sp_ram_arb2 #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned INIT_ZERO  = 1
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic [1:0]                 ReqN_SI,
  output logic [1:0]                 GntN_SO,
  input  logic [1:0]                 WrEnN_SI,
  input  logic [1:0][7:0]            BEnN_SI,
  input  logic [1:0][63:0]           WrDataN_SI,
  input  logic [1:0][ADDR_WIDTH-1:0] AddrN_SI,
  output logic [1:0]                 RValidN_SO,
  output logic [1:0][63:0]           RdDataN_DO,
  output logic                       InitDone_SO,
  output logic                       RamCSel_SO,
  output logic                       RamWrEn_SO,
  output logic [7:0]                 RamBEn_SO,
  output logic [63:0]                RamWrData_DO,
  output logic [ADDR_WIDTH-1:0]      RamAddr_DO,
  input  logic [63:0]                RamRdData_DI
);

  localparam int unsigned Lat = 1 + OUT_REGS;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DATA_DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;
  localparam state_e StReset = (INIT_ZERO != 0) ? StInit : StRun;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rr_q, rr_d;
  logic                  init_done_q;
  logic                  win;
  logic [1:0]            gnt;

  logic                  wr_en_q;
  logic [7:0]            ben_q;
  logic [63:0]           wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [Lat-1:0]        pv_q, pid_q, prd_q;
  logic [1:0][63:0]      rdata_q;

  // RAM controls are combinational so the RAM samples the access at the end of its grant cycle.
  // Qualifying with Rst_RBI keeps all strobes low while reset is held.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_d         = rr_q;
    gnt          = 2'b00;
    win          = 1'b0;
    RamCSel_SO   = 1'b0;
    RamWrEn_SO   = wr_en_q;
    RamBEn_SO    = ben_q;
    RamWrData_DO = wdata_q;
    RamAddr_DO   = addr_q;
    unique case (state_q)
      StInit: begin
        if (Rst_RBI) begin
          RamCSel_SO   = 1'b1;
          RamWrEn_SO   = 1'b1;
          RamBEn_SO    = 8'hFF;
          RamWrData_DO = '0;
          RamAddr_DO   = cnt_q;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
      end
      StRun: begin
        if (Rst_RBI && (ReqN_SI != 2'b00)) begin
          win          = (ReqN_SI == 2'b11) ? rr_q : ReqN_SI[1];
          gnt[win]     = 1'b1;
          rr_d         = ~win;
          RamCSel_SO   = 1'b1;
          RamWrEn_SO   = WrEnN_SI[win];
          RamBEn_SO    = BEnN_SI[win];
          RamWrData_DO = WrDataN_SI[win];
          RamAddr_DO   = AddrN_SI[win];
        end
      end
      default: state_d = StReset;
    endcase
  end

  assign GntN_SO     = gnt;
  assign InitDone_SO = init_done_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q     <= StReset;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      wr_en_q     <= 1'b0;
      ben_q       <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      init_done_q <= (state_d == StRun);
      if (RamCSel_SO) begin
        wr_en_q <= RamWrEn_SO;
        ben_q   <= RamBEn_SO;
        wdata_q <= RamWrData_DO;
        addr_q  <= RamAddr_DO;
      end
    end
  end

  // Response pipeline: {valid, port id, is_read}, Lat stages deep to match RAM read latency.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      pv_q    <= '0;
      pid_q   <= '0;
      prd_q   <= '0;
      rdata_q <= '0;
    end else begin
      pv_q[0]  <= |gnt;
      pid_q[0] <= win;
      prd_q[0] <= ~WrEnN_SI[win];
      for (int unsigned i = 1; i < Lat; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
        prd_q[i] <= prd_q[i-1];
      end
      if (pv_q[Lat-1] && prd_q[Lat-1]) begin
        rdata_q[pid_q[Lat-1]] <= RamRdData_DI;
      end
    end
  end

  always_comb begin
    RValidN_SO = 2'b00;
    RdDataN_DO = rdata_q;
    if (pv_q[Lat-1]) begin
      RValidN_SO[pid_q[Lat-1]] = 1'b1;
      if (prd_q[Lat-1]) begin
        RdDataN_DO[pid_q[Lat-1]] = RamRdData_DI;
      end
    end
  end

`ifndef SYNTHESIS
  addr_in_range_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    (gnt != 2'b00) |-> (32'(AddrN_SI[win]) < DATA_DEPTH))
    else $error("granted address beyond DATA_DEPTH");
`endif

endmodule

// File: tb/tb_sync_sp_ram_arb2.sv
// Bench for sync_sp_ram_arb2: directed and random traffic checked against a transaction-level
// model of memory contents, arbitration order and response timing.
module tb_sync_sp_ram_arb2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // DUT A: zero fill, OUT_REGS=0
  logic               rst_a_n;
  logic [1:0]         a_req, a_gnt, a_we, a_rv;
  logic [1:0][7:0]    a_ben;
  logic [1:0][63:0]   a_wd, a_rd;
  logic [1:0][AW-1:0] a_addr;
  logic               a_done, a_csel, a_rwe;
  logic [7:0]         a_rben;
  logic [63:0]        a_rwd, a_rrd;
  logic [AW-1:0]      a_raddr;

  // DUT B: no fill, OUT_REGS=1
  logic               rst_b_n;
  logic [1:0]         b_req, b_gnt, b_we, b_rv;
  logic [1:0][7:0]    b_ben;
  logic [1:0][63:0]   b_wd, b_rd;
  logic [1:0][AW-1:0] b_addr;
  logic               b_done, b_csel, b_rwe;
  logic [7:0]         b_rben;
  logic [63:0]        b_rwd, b_rrd, b_rd1;
  logic [AW-1:0]      b_raddr;

  sync_sp_ram_arb2 #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(0), .INIT_ZERO(1)) u_dut_a (
    .Clk_CI(clk), .Rst_RBI(rst_a_n), .ReqN_SI(a_req), .GntN_SO(a_gnt), .WrEnN_SI(a_we),
    .BEnN_SI(a_ben), .WrDataN_SI(a_wd), .AddrN_SI(a_addr), .RValidN_SO(a_rv),
    .RdDataN_DO(a_rd), .InitDone_SO(a_done), .RamCSel_SO(a_csel), .RamWrEn_SO(a_rwe),
    .RamBEn_SO(a_rben), .RamWrData_DO(a_rwd), .RamAddr_DO(a_raddr), .RamRdData_DI(a_rrd)
  );

  sync_sp_ram_arb2 #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(1), .INIT_ZERO(0)) u_dut_b (
    .Clk_CI(clk), .Rst_RBI(rst_b_n), .ReqN_SI(b_req), .GntN_SO(b_gnt), .WrEnN_SI(b_we),
    .BEnN_SI(b_ben), .WrDataN_SI(b_wd), .AddrN_SI(b_addr), .RValidN_SO(b_rv),
    .RdDataN_DO(b_rd), .InitDone_SO(b_done), .RamCSel_SO(b_csel), .RamWrEn_SO(b_rwe),
    .RamBEn_SO(b_rben), .RamWrData_DO(b_rwd), .RamAddr_DO(b_raddr), .RamRdData_DI(b_rrd)
  );

  // Behavioural RAMs standing in for SyncSpRamBeNx64
  logic [63:0] mem_a [DEPTH];
  logic [63:0] mem_b [DEPTH];

  always @(posedge clk) begin
    if (a_csel) begin
      if (a_rwe) begin
        for (int b = 0; b < 8; b++) if (a_rben[b]) mem_a[a_raddr][b*8 +: 8] <= a_rwd[b*8 +: 8];
      end else begin
        a_rrd <= mem_a[a_raddr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_csel) begin
      if (b_rwe) begin
        for (int b = 0; b < 8; b++) if (b_rben[b]) mem_b[b_raddr][b*8 +: 8] <= b_rwd[b*8 +: 8];
      end else begin
        b_rd1 <= mem_b[b_raddr];
      end
    end
    b_rrd <= b_rd1;
  end

  // Reference model for DUT A
  typedef struct {
    int          due;
    int          port;
    bit          rd;
    logic [63:0] data;
  } resp_t;

  resp_t         q[$];
  logic [63:0]   ref_mem [DEPTH];
  logic [63:0]   exp_rd [2];
  bit            rd_known [2];
  int            last_win;
  int            cyc;
  logic [AW-1:0] last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bmask(input logic [7:0] be);
    for (int b = 0; b < 8; b++) bmask[b*8 +: 8] = {8{be[b]}};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;
    q.delete();
    for (int p = 0; p < 2; p++) begin
      exp_rd[p]   = 64'd0;
      rd_known[p] = 1'b1;
    end
    last_win  = 1;  // port 0 preferred first
    cyc       = 0;
    last_addr = AW'(DEPTH - 1);
  endtask

  // One RUN cycle of DUT A: inputs already driven at posedge+1, checks at negedge.
  task automatic step_a();
    int          w;
    int          rp;
    logic [1:0]  eg;
    logic [1:0]  erv;
    logic [63:0] m;
    resp_t       e;
    @(negedge clk);
    w = -1;
    if (a_req == 2'b11) w = 1 - last_win;
    else if (a_req[0]) w = 0;
    else if (a_req[1]) w = 1;
    eg = 2'b00;
    if (w >= 0) eg[w] = 1'b1;
    check("gnt", 64'(a_gnt), 64'(eg));
    check("csel", 64'(a_csel), (w >= 0) ? 64'd1 : 64'd0);
    if (w < 0) check("addr_hold", 64'(a_raddr), 64'(last_addr));
    erv = 2'b00;
    rp  = -1;
    if (q.size() > 0 && q[0].due == cyc) begin
      e  = q.pop_front();
      rp = e.port;
      erv[rp] = 1'b1;
      if (e.rd) begin
        check("rdata", a_rd[rp], e.data);
        exp_rd[rp]   = e.data;
        rd_known[rp] = 1'b1;
      end else begin
        rd_known[rp] = 1'b0;
      end
    end
    check("rvalid", 64'(a_rv), 64'(erv));
    for (int p = 0; p < 2; p++) begin
      if (p != rp && rd_known[p]) check("rdata_hold", a_rd[p], exp_rd[p]);
    end
    if (w >= 0) begin
      e.due  = cyc + 1;
      e.port = w;
      e.rd   = !a_we[w];
      e.data = ref_mem[a_addr[w]];
      if (a_we[w]) begin
        m = bmask(a_ben[w]);
        ref_mem[a_addr[w]] = (ref_mem[a_addr[w]] & ~m) | (a_wd[w] & m);
      end
      q.push_back(e);
      last_win  = w;
      last_addr = a_addr[w];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expects to start at posedge+1 of the first cycle after reset release.
  task automatic init_sweep_a();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("init_csel", 64'(a_csel), 64'd1);
      check("init_we", 64'(a_rwe), 64'd1);
      check("init_ben", 64'(a_rben), 64'hFF);
      check("init_wdata", a_rwd, 64'd0);
      check("init_addr", 64'(a_raddr), 64'(i));
      check("init_gnt", 64'(a_gnt), 64'd0);
      check("init_rvalid", 64'(a_rv), 64'd0);
      check("init_done_low", 64'(a_done), 64'd0);
      @(posedge clk);
      #1;
    end
    check("init_done", 64'(a_done), 64'd1);
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    a_req = 2'b01; a_we = 2'b00; a_ben = '0; a_wd = '0; a_addr = '0;
    b_req = 2'b01; b_we = 2'b00; b_ben = '0; b_wd = '0; b_addr = '0;
    a_addr[0] = AW'(5);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(a_gnt), 64'd0);
    check("rst_rv", 64'(a_rv), 64'd0);
    check("rst_rd0", a_rd[0], 64'd0);
    check("rst_rd1", a_rd[1], 64'd0);
    check("rst_done", 64'(a_done), 64'd0);
    check("rst_csel", 64'(a_csel), 64'd0);
    check("rst_ram", {a_rwd[55:0], a_rben}, 64'd0);
    check("rst_b_gnt", 64'(b_gnt), 64'd0);

    // Zero fill, then the pending read of address 5 is granted in the first RUN cycle
    rst_a_n = 1'b1;
    init_sweep_a();
    reset_model();
    step_a();
    a_req = 2'b00;
    step_a();

    // Partial-byte write then read back
    a_req = 2'b01; a_we[0] = 1'b1; a_ben[0] = 8'h0F;
    a_wd[0] = 64'h0123456789ABCDEF; a_addr[0] = AW'(3);
    step_a();
    a_we[0] = 1'b0;
    step_a();
    a_req = 2'b00;
    step_a();
    check("t2_rdata", a_rd[0], 64'h0000000089ABCDEF);

    // Contention for six cycles, mixed directions
    a_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      a_we = 2'(i);
      a_ben[0] = 8'hFF; a_ben[1] = 8'hF0;
      a_wd[0] = {2{$urandom}}; a_wd[1] = {2{$urandom}};
      a_addr[0] = AW'(i); a_addr[1] = AW'(8 + i);
      step_a();
    end
    a_req = 2'b00;
    step_a();

    // Preload via port 0, then port 1 streams reads back-to-back
    a_req = 2'b01; a_we = 2'b01; a_ben[0] = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      a_wd[0] = 64'(i * 8'h11); a_addr[0] = AW'(i);
      step_a();
    end
    a_req = 2'b10; a_we = 2'b00;
    for (int i = 0; i < 8; i++) begin
      a_addr[1] = AW'(i);
      step_a();
    end
    a_req = 2'b00;
    step_a();

    // Random traffic including read-after-write to hot addresses
    for (int i = 0; i < 300; i++) begin
      a_req = 2'($urandom_range(0, 3));
      a_we  = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        a_ben[p]  = 8'($urandom);
        a_wd[p]   = {$urandom, $urandom};
        a_addr[p] = AW'($urandom_range(0, 3));
      end
      step_a();
    end

    // Reset with reads in flight
    a_req = 2'b01; a_we = 2'b00; a_addr[0] = AW'(1);
    step_a();
    a_req = 2'b10; a_addr[1] = AW'(2);
    step_a();
    a_req = 2'b11;
    rst_a_n = 1'b0;
    #1;
    check("midrst_rv", 64'(a_rv), 64'd0);
    check("midrst_gnt", 64'(a_gnt), 64'd0);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    init_sweep_a();
    reset_model();
    step_a();
    step_a();
    a_req = 2'b00;
    step_a();

    // DUT B: no fill, grant right after release, latency 2
    b_req = 2'b01; b_we = 2'b01; b_ben[0] = 8'hFF; b_wd[0] = 64'd0; b_addr[0] = AW'(3);
    rst_b_n = 1'b1;
    @(negedge clk);
    check("b_gnt_c0", 64'(b_gnt), 64'd1);
    check("b_rv_c0", 64'(b_rv), 64'd0);
    @(posedge clk); #1;
    b_ben[0] = 8'h0F; b_wd[0] = 64'h0123456789ABCDEF;
    @(negedge clk);
    check("b_done", 64'(b_done), 64'd1);
    check("b_gnt_c1", 64'(b_gnt), 64'd1);
    check("b_rv_c1", 64'(b_rv), 64'd0);
    @(posedge clk); #1;
    b_we = 2'b00;
    @(negedge clk);
    check("b_gnt_c2", 64'(b_gnt), 64'd1);
    check("b_rv_c2", 64'(b_rv), 64'd1);
    @(posedge clk); #1;
    b_req = 2'b00;
    @(negedge clk);
    check("b_csel_c3", 64'(b_csel), 64'd0);
    check("b_rv_c3", 64'(b_rv), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_rv_c4", 64'(b_rv), 64'd1);
    check("b_rdata_c4", b_rd[0], 64'h0000000089ABCDEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("b_rv_c5", 64'(b_rv), 64'd0);
    check("b_rdata_hold", b_rd[0], 64'h0000000089ABCDEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
